// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: registered round-robin arbiter with a hold limit.
// Turns a multi-hot request vector into a registered one-hot grant plus its
// binary index. The owner keeps the grant while it requests. Once it has
// held the grant for MAX_HOLD cycles, it is rotated away if others wait.
module rr_arbiter_8 #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 4,
  parameter int IDXW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDXW-1:0]  gnt_idx,
  output logic             gnt_valid
);

  // Hold counter counts 1..MAX_HOLD and saturates, so it never wraps.
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [IDXW-1:0]   gnt_idx_reg, gnt_idx_next;
  logic              gnt_valid_reg, gnt_valid_next;
  logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [IDXW-1:0]   last_ptr_reg, last_ptr_next;

  // Search bases. IDXW-bit arithmetic gives the modulo-N_REQ wrap for free,
  // because N_REQ is a power of two.
  logic [IDXW-1:0]   idle_base, busy_base;
  logic [N_REQ-1:0]  others;
  logic [N_REQ-1:0]  idle_rot, busy_rot;
  logic [IDXW-1:0]   idle_win, busy_win;
  logic              idle_any, busy_any;
  logic              owner_req;

  assign idle_base = last_ptr_reg + IDXW'(1);
  assign busy_base = gnt_idx_reg + IDXW'(1);
  // In BUSY, "others" means every requester except the current owner.
  assign others    = req & ~gnt_reg;
  assign owner_req = req[gnt_idx_reg];
  assign idle_any  = |req;
  assign busy_any  = |others;

  // Rotate each request vector so that bit 0 is the first candidate in the
  // circular scan. A plain lowest-set-bit search then yields the offset.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign idle_rot[gi] = req[idle_base + IDXW'(gi)];
      assign busy_rot[gi] = others[busy_base + IDXW'(gi)];
    end
  endgenerate

  // Index of the lowest set bit (0 when none; callers gate with *_any).
  function automatic logic [IDXW-1:0] first_set(input logic [N_REQ-1:0] v);
    first_set = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDXW'(i);
    end
  endfunction

  assign idle_win = idle_base + first_set(idle_rot);
  assign busy_win = busy_base + first_set(busy_rot);

  // Next-state and next-grant selection for the IDLE/BUSY arbiter.
  always_comb begin
    state_next     = state_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    hold_cnt_next  = hold_cnt_reg;
    last_ptr_next  = last_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (en && idle_any) begin
          state_next     = BUSY;
          gnt_idx_next   = idle_win;
          gnt_valid_next = 1'b1;
          hold_cnt_next  = HOLD_ONE;
        end else begin
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
          hold_cnt_next  = '0;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          // Release: hand over without a bubble if allowed, else go idle.
          last_ptr_next = gnt_idx_reg;
          if (en && busy_any) begin
            gnt_idx_next  = busy_win;
            hold_cnt_next = HOLD_ONE;
          end else begin
            state_next     = IDLE;
            gnt_idx_next   = '0;
            gnt_valid_next = 1'b0;
            hold_cnt_next  = '0;
          end
        end else if (hold_cnt_reg == HOLD_MAX) begin
          // Forced rotation only when enabled and someone else is waiting;
          // otherwise the owner keeps the grant and the count stays saturated.
          if (en && busy_any) begin
            last_ptr_next = gnt_idx_reg;
            gnt_idx_next  = busy_win;
            hold_cnt_next = HOLD_ONE;
          end
        end else if (en) begin
          hold_cnt_next = hold_cnt_reg + HOLD_ONE;
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_idx_next   = '0;
        gnt_valid_next = 1'b0;
        hold_cnt_next  = '0;
      end
    endcase
  end

  // One-hot decode of the next grant index, gated by the next valid flag.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign gnt_next[gi] = gnt_valid_next & (gnt_idx_next == IDXW'(gi));
    end
  endgenerate

  // State and output registers. Reset clears the grant immediately and
  // restarts the priority at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      hold_cnt_reg  <= '0;
      last_ptr_reg  <= IDXW'(N_REQ - 1);
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      hold_cnt_reg  <= hold_cnt_next;
      last_ptr_reg  <= last_ptr_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8. Directed scenarios with fixed expectations are
// followed by randomized requests. Every cycle is compared against a
// behavioural model of the round-robin rules built from integer owner,
// hold and last-pointer variables.
module tb_rr_arbiter_8;
  localparam int N    = 8;
  localparam int MAXH = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         gnt_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: owner = -1 when nothing is granted.
  int m_owner;
  int m_hold;
  int m_last;

  rr_arbiter_8 #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // First set bit of v found by scanning circularly after 'after'.
  function automatic int winner(input logic [N-1:0] v, input int after);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (after + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = N - 1;
  endtask

  task automatic model_step();
    logic [N-1:0] oth;
    if (m_owner < 0) begin
      if (en && (req != 0)) begin
        m_owner = winner(req, m_last);
        m_hold  = 1;
      end
    end else begin
      oth = req;
      oth[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        m_last = m_owner;
        if (en && (oth != 0)) begin
          m_owner = winner(oth, m_last);
          m_hold  = 1;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else if (m_hold == MAXH) begin
        if (en && (oth != 0)) begin
          m_last  = m_owner;
          m_owner = winner(oth, m_last);
          m_hold  = 1;
        end
      end else if (en) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, ".valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  // One clock: model advances on the edge, DUT is sampled 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    $display("cyc %0d %s req=%02h en=%0b gnt=%02h idx=%0d valid=%0b",
             cyc, tag, req, en, gnt, gnt_idx, gnt_valid);
    compare_model(tag);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.idx", 32'(gnt_idx), 32'd0);
    check("rst.valid", 32'(gnt_valid), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 8'hFF;
    model_reset();
    #1;

    // Reset with all requesting: index 0 wins first.
    do_reset();
    cycle("first");
    check("first.gnt_const", 32'(gnt), 32'h01);
    check("first.idx_const", 32'(gnt_idx), 32'd0);

    // Lone requester keeps the grant indefinitely.
    req = 8'h20;
    for (int c = 0; c < 10; c++) begin
      cycle("single");
      check("single.gnt_const", 32'(gnt), 32'h20);
      check("single.idx_const", 32'(gnt_idx), 32'd5);
    end

    // Two requesters at opposite ends alternate every MAX_HOLD cycles.
    do_reset();
    req = 8'h81;
    for (int c = 0; c < 16; c++) begin
      cycle("wrap");
      check("wrap.idx_const", 32'(gnt_idx), ((c / MAXH) % 2 == 1) ? 32'd7 : 32'd0);
      check("wrap.valid_const", 32'(gnt_valid), 32'd1);
    end

    // Owner 2 releases with 1 and 4 pending: 4 next, then 1, with no gap.
    do_reset();
    req = 8'h04;
    cycle("rel");
    check("rel.idx2", 32'(gnt_idx), 32'd2);
    req = 8'h12;
    cycle("rel");
    check("rel.idx4", 32'(gnt_idx), 32'd4);
    check("rel.valid4", 32'(gnt_valid), 32'd1);
    cycle("rel");
    cycle("rel");
    req = 8'h02;
    cycle("rel");
    check("rel.idx1", 32'(gnt_idx), 32'd1);
    check("rel.valid1", 32'(gnt_valid), 32'd1);

    // en=0 freezes rotation: idx3 stays past the hold limit.
    do_reset();
    req = 8'h08;
    for (int c = 0; c < 5; c++) cycle("hold");
    req = 8'h29;
    en  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle("frozen");
      check("frozen.idx3", 32'(gnt_idx), 32'd3);
    end
    req = 8'h21;
    cycle("frozen_rel");
    check("frozen_rel.gnt0", 32'(gnt), 32'd0);
    check("frozen_rel.valid0", 32'(gnt_valid), 32'd0);
    cycle("frozen_idle");
    check("frozen_idle.gnt0", 32'(gnt), 32'd0);
    en = 1'b1;
    cycle("resume");
    check("resume.idx5", 32'(gnt_idx), 32'd5);

    // Reset in the middle of a grant, then priority restarts at 0.
    do_reset();
    req = 8'h40;
    cycle("mid");
    check("mid.gnt40", 32'(gnt), 32'h40);
    #2;
    do_reset();
    req = 8'h48;
    cycle("after_rst");
    check("after_rst.idx3", 32'(gnt_idx), 32'd3);

    // Randomized traffic against the model.
    r = 8'h00;
    for (int it = 0; it < 2000; it++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        2: r = r;
        default: r = r ^ (8'h01 << $urandom_range(0, 7));
      endcase
      req = r;
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Registered round-robin arbiter that shares one resource among N_REQ requesters.
- Converts a multi-hot request vector into a single one-hot grant plus its binary index. This is the sequenced counterpart of the team's 8-to-3 encoder.
- Downstream muxes select the owner's datapath directly with gnt_idx.
- A hold limit forces rotation, so no requester can starve others.

Parameters:
- N_REQ, 8, number of requesters; must be a power of 2, minimum 2.
- MAX_HOLD, 4, maximum consecutive grant cycles before a forced rotation when others are waiting; minimum 1.
- IDXW, $clog2(N_REQ), width of the grant index; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants.
- req  input  N_REQ  request vector, one bit per requester, level-sensitive.
- gnt  output  N_REQ  registered one-hot grant, or all zero.
- gnt_idx  output  IDXW  registered binary index of the granted requester.
- gnt_valid  output  1  registered; 1 when a grant is held.

Behaviour:
- Reset (async assert, sync deassert assumed external):
  - gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, hold_cnt=0.
  - last_ptr=N_REQ-1, so index 0 has first priority after reset.
- Invariants:
  - gnt is one-hot when gnt_valid=1, all zero otherwise.
  - gnt[gnt_idx]=1 whenever gnt_valid=1.
  - gnt_idx=0 whenever gnt_valid=0.
- Winner function:
  - Picks the first set req bit scanning circularly from (last_ptr+1) mod N_REQ upward.
  - Wraps from N_REQ-1 to 0.
  - In BUSY, the current owner's bit is excluded when looking for "others".
- Latency: a request is seen on edge k and the grant is visible after edge k. One cycle from req to gnt, with no combinational path from req to outputs.
- State IDLE:
  - If en=1 and |req, grant the winner: state=BUSY, hold_cnt=1, gnt_valid=1.
  - Otherwise remain in IDLE with outputs zero.
- State BUSY (owner = gnt_idx), evaluated in priority order at each edge:
  1. req[owner]=0 (release): last_ptr=owner. If en=1 and another request is pending, grant the next winner directly with no idle bubble and hold_cnt=1. Otherwise go to IDLE and clear outputs.
  2. req[owner]=1, hold_cnt==MAX_HOLD, en=1, another request pending (forced rotation): last_ptr=owner, grant the next winner, hold_cnt=1.
  3. req[owner]=1, hold_cnt==MAX_HOLD, no other request pending: keep the grant; hold_cnt saturates at MAX_HOLD.
  4. req[owner]=1, hold_cnt<MAX_HOLD: keep the grant; hold_cnt+=1, but only if en=1.
- en=0:
  - No new grant is issued from IDLE, and no rotation occurs.
  - The current owner keeps the grant until it drops req, then the block goes to IDLE.
  - hold_cnt is frozen.
- Simultaneous events: on a release edge with multiple pending requesters, exactly one is granted, chosen by the circular priority from owner+1.
- Reset mid-grant: outputs clear immediately (asynchronously), and priority restarts at index 0.
- hold_cnt width is $clog2(MAX_HOLD+1) and it never wraps.

Test Plan:
- Reset with req=8'hFF, then release rst_n with en=1: gnt=8'h01 and gnt_idx=0 one cycle later.
- Single requester, req=8'h20 held for 10 cycles: gnt=8'h20 and gnt_idx=5 for all cycles. No rotation; hold_cnt saturates at 4.
- req=8'h81 held, MAX_HOLD=4:
  - Grant sequence is idx0 for 4 cycles, idx7 for 4 cycles, idx0, and so on (wrap-around check).
  - Exactly one grant in every cycle, no idle gap.
- Owner idx2 drops req while req=8'h12 is pending: next edge grants idx4 (search starts at 3), then idx1 after 4 drops.
  - Check gnt_valid never falls between grants.
- en=0 during BUSY(idx3) with other requests pending: idx3 holds beyond MAX_HOLD.
  - When idx3 drops req, the block enters IDLE with gnt=0.
  - When en returns to 1, the next grant goes to the circular winner after 3.
- Assert rst_n=0 mid-grant (gnt=8'h40): all outputs are 0 before the next clock edge.
  - After reset, with req=8'h48, grant goes to idx3, not idx6.
